seq_alu: RTL
============

// Module: seq_alu
// PURPOSE
//   Multi-cycle, handshaked successor to the combinational add/multiply ALU.
//   Supports four ops: add, subtract, AND and unsigned multiply. Multiply uses an
//   iterative shift-add datapath, one partial product per clock.
//   Operands are latched on accept. The result is held until the consumer takes it.
//   Sits between an operand source (valid/ready) and a result sink (valid/ready).
// PARAMETERS
//   p_width  4  operand width in bits (>=2); result width is 2*p_width
// PORTS
//   i_w_clk        in   1            single clock, all state updates on rising edge
//   i_w_reset      in   1            synchronous, active-high reset
//   i_w_valid      in   1            operand/op request valid
//   o_w_ready      out  1            block can accept a request
//   i_w_a          in   p_width      operand A (unsigned)
//   i_w_b          in   p_width      operand B (unsigned)
//   i_w_op         in   2            00 add, 01 sub, 10 mul, 11 and
//   o_w_out        out  2*p_width    result
//   o_w_valid      out  1            result valid
//   i_w_out_ready  in   1            sink accepts result
// BEHAVIOUR
//   Reset (sync, high): state=IDLE; o_w_ready=1, o_w_valid=0, o_w_out=0; counter/acc=0.
//   Reset overrides everything, including an in-flight multiply, which is dropped.
//   Accept = i_w_valid & o_w_ready at a rising edge; A, B and op are latched then.
//   Inputs are ignored outside IDLE.
//   FSM states and transitions:
//     IDLE: o_w_ready=1.
//       accept, op!=10 -> DONE; o_w_out is written with the result at the same edge.
//       accept, op==10 -> MUL; acc=0, mcand=A zero-extended to 2*p_width, mplier=B,
//         cnt=p_width.
//     MUL: o_w_ready=0, o_w_valid=0. Each cycle:
//       if mplier[0], acc += mcand; then mcand<<=1, mplier>>=1, cnt-=1.
//       On the step where cnt reaches 0: o_w_out=final acc -> DONE.
//       Exactly p_width cycles are spent in MUL.
//     DONE: o_w_valid=1, o_w_ready=0; o_w_out is held stable.
//       i_w_out_ready=1 -> IDLE (o_w_valid falls next cycle).
//   Latency (accept edge -> o_w_valid high): add/sub/and 1 cycle; mul p_width+1 cycles.
//   Throughput: one bubble cycle in IDLE between results; no accept during DONE.
//   Arithmetic (result zero-padded or extended to 2*p_width):
//     add: {0,A}+{0,B}, p_width+1 bits, zero-extended (carry kept).
//     sub: {0,A}-{0,B}, p_width+1 bits two's complement, sign-extended.
//     and: A&B, zero-extended.
//     mul: full unsigned A*B, no truncation (max (2^p-1)^2 fits).
//   o_w_out keeps the last result after the handshake; it is 0 only after reset.
//   i_w_out_ready while o_w_valid=0 has no effect.
//   Accept and result handshake never coincide (ready=0 in DONE).
//   cnt width: $clog2(p_width+1). No X may reach any output after reset.
// STRUCTURE
//   Shared header alu_defs.vh: localparam opcodes (OP_ADD=2'b00, OP_SUB=2'b01,
//     OP_MUL=2'b10, OP_AND=2'b11) and FSM encodings (S_IDLE, S_MUL, S_DONE).
//     The header is reused by the testbench.
//   One sub-module: shift_add_step, a combinational single iteration.
//     Inputs: acc, mcand, mplier. Outputs: next acc, mcand, mplier.
//     Parametrised by p_width and instantiated once.
//   FSM, operand registers, counter and output register live in seq_alu.
// TESTING (p_width=4 unless noted)
//   1. Reset, then add A=15, B=1 -> one cycle after accept: o_w_valid=1, o_w_out=8'h10.
//   2. Sub A=3, B=5 -> o_w_out=8'hFE after 1 cycle.
//      And A=4'hC, B=4'hA -> o_w_out=8'h08.
//   3. Mul A=15, B=15 -> o_w_ready=0 for 4 cycles.
//      o_w_valid rises 5 cycles after accept with o_w_out=8'hE1.
//      Change A, B, op during MUL -> result unchanged.
//   4. Backpressure: hold i_w_out_ready=0 for 10 cycles in DONE ->
//      o_w_valid, o_w_out stable; no accept.
//      Raise i_w_out_ready -> IDLE, o_w_ready=1 next cycle.
//   5. Assert i_w_reset on the 2nd MUL cycle of 7*9 -> next cycle IDLE,
//      o_w_out=0, o_w_valid=0.
//      A new mul 7*9 -> 8'h3F.
//   6. p_width=8: mul 255*255 -> 16'hFE01 after 9 cycles.
//      Add 255+255 -> 16'h01FE. Sub 0-1 -> 16'hFFFF.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared opcode and FSM encodings for the sequential ALU and its testbench.
package seq_alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_alu_shift_add_step.sv
// One combinational iteration of the unsigned shift-add multiplier.
module shift_add_step #(
    parameter int p_width = 4
) (
    input  logic [2*p_width-1:0] i_w_acc,
    input  logic [2*p_width-1:0] i_w_mcand,
    input  logic [p_width-1:0]   i_w_mplier,
    output logic [2*p_width-1:0] o_w_acc,
    output logic [2*p_width-1:0] o_w_mcand,
    output logic [p_width-1:0]   o_w_mplier
);

    assign o_w_acc    = i_w_mplier[0] ? (i_w_acc + i_w_mcand) : i_w_acc;
    assign o_w_mcand  = i_w_mcand << 1;
    assign o_w_mplier = i_w_mplier >> 1;

endmodule

// File: rtl/seq_alu.sv
// Handshaked multi-cycle ALU: add/sub/and finish in one cycle, mul iterates
// one partial product per clock.
//   state  | meaning
//   S_IDLE | ready for a request
//   S_MUL  | shift-add iterations in progress
//   S_DONE | result valid, waiting for the sink
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int p_width = 4
) (
    input  logic                 i_w_clk,
    input  logic                 i_w_reset,
    input  logic                 i_w_valid,
    output logic                 o_w_ready,
    input  logic [p_width-1:0]   i_w_a,
    input  logic [p_width-1:0]   i_w_b,
    input  logic [1:0]           i_w_op,
    output logic [2*p_width-1:0] o_w_out,
    output logic                 o_w_valid,
    input  logic                 i_w_out_ready
);

    localparam int OW = 2 * p_width;
    localparam int CW = $clog2(p_width + 1);

    state_t              r_state;
    logic                r_ready;
    logic                r_valid;
    logic [OW-1:0]       r_out;
    logic [OW-1:0]       r_acc;
    logic [OW-1:0]       r_mcand;
    logic [p_width-1:0]  r_mplier;
    logic [CW-1:0]       r_cnt;

    logic [p_width:0]    w_sum;
    logic [p_width:0]    w_diff;
    logic [OW-1:0]       w_result;
    logic [OW-1:0]       w_acc_nxt;
    logic [OW-1:0]       w_mcand_nxt;
    logic [p_width-1:0]  w_mplier_nxt;

    assign w_sum  = {1'b0, i_w_a} + {1'b0, i_w_b};
    assign w_diff = {1'b0, i_w_a} - {1'b0, i_w_b};

    // Single-cycle results; the subtract keeps its borrow as a sign bit.
    always_comb begin
        w_result = '0;
        case (i_w_op)
            OP_ADD:  w_result = {{(p_width-1){1'b0}}, w_sum};
            OP_SUB:  w_result = {{(p_width-1){w_diff[p_width]}}, w_diff};
            OP_AND:  w_result = {{p_width{1'b0}}, i_w_a & i_w_b};
            default: w_result = '0;
        endcase
    end

    shift_add_step #(.p_width(p_width)) u_step (
        .i_w_acc    (r_acc),
        .i_w_mcand  (r_mcand),
        .i_w_mplier (r_mplier),
        .o_w_acc    (w_acc_nxt),
        .o_w_mcand  (w_mcand_nxt),
        .o_w_mplier (w_mplier_nxt)
    );

    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_out    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_w_valid) begin
                        r_ready <= 1'b0;
                        if (i_w_op == OP_MUL) begin
                            r_acc    <= '0;
                            r_mcand  <= OW'(i_w_a);
                            r_mplier <= i_w_b;
                            r_cnt    <= CW'(p_width);
                            r_state  <= S_MUL;
                        end else begin
                            r_out   <= w_result;
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= w_mcand_nxt;
                    r_mplier <= w_mplier_nxt;
                    r_cnt    <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_out   <= w_acc_nxt;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_w_out_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_w_ready = r_ready;
    assign o_w_valid = r_valid;
    assign o_w_out   = r_out;

endmodule
